// File: rtl/byte_serializer_pkg.sv
// Shared types and default constants for the byte serializer.
package byte_serializer_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StGap,
    StWait
  } ser_state_t;

  localparam int unsigned SER_WIDTH    = 8;
  localparam int unsigned SER_BIT_HOLD = 50;
  localparam int unsigned SER_BIT_GAP  = 50;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/byte_serializer_phase_timer.sv
// Loadable down-counter; done_o is high once the count has reached zero.
module byte_serializer_phase_timer #(
  parameter int unsigned Width = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  // Loading N-1 on phase entry makes the phase last exactly N cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/byte_serializer.sv
// Parallel-to-serial word replay with paced write strobes and downstream stall.
// Define BYTE_SERIALIZER_LSB_FIRST_EN to emit bits LSB first (default MSB first).
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned WIDTH    = SER_WIDTH,
  parameter int unsigned BIT_HOLD = SER_BIT_HOLD,
  parameter int unsigned BIT_GAP  = SER_BIT_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             stall_in,
  output logic             data_out,
  output logic             write_out,
  output logic             busy_out
);

  localparam int unsigned TimerW = $clog2(max_u(BIT_HOLD, BIT_GAP) + 1);
  localparam int unsigned CntW   = $clog2(WIDTH + 1);
  localparam logic [TimerW-1:0] HoldLoad = TimerW'(BIT_HOLD - 1);
  localparam logic [TimerW-1:0] GapLoad  = TimerW'(BIT_GAP - 1);

  ser_state_t        state_q, state_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d, sreg_shifted;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              tmr_load, tmr_done, cur_bit;
  logic [TimerW-1:0] tmr_val;

`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
  assign cur_bit      = sreg_q[0];
  assign sreg_shifted = sreg_q >> 1;
`else
  assign cur_bit      = sreg_q[WIDTH-1];
  assign sreg_shifted = sreg_q << 1;
`endif

  byte_serializer_phase_timer #(
    .Width(TimerW)
  ) u_phase_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    tmr_load  = 1'b0;
    tmr_val   = HoldLoad;
    unique case (state_q)
      StIdle: begin
        if (valid_in && ready_out) begin
          sreg_d    = data_in;
          bit_cnt_d = '0;
          tmr_load  = 1'b1;
          state_d   = stall_in ? StWait : StHold;
        end
      end
      StHold: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = GapLoad;
          state_d  = StGap;
        end
      end
      StGap: begin
        if (tmr_done) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == CntW'(WIDTH - 1)) begin
            state_d = StIdle;
          end else begin
            sreg_d   = sreg_shifted;
            tmr_load = 1'b1;
            state_d  = stall_in ? StWait : StHold;
          end
        end
      end
      StWait: begin
        if (!stall_in) begin
          tmr_load = 1'b1;
          state_d  = StHold;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ready_out = (state_q == StIdle) && !rst;
  assign busy_out  = (state_q != StIdle);
  assign write_out = (state_q == StHold);
  // Idle keeps the line quiet rather than showing a stale residue bit.
  assign data_out  = busy_out & cur_bit;

endmodule

// File: tb/tb_byte_serializer.sv
// Randomized self-checking bench for byte_serializer against a frame-trace model.
module tb_byte_serializer;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned BIT_HOLD = 2;
  localparam int unsigned BIT_GAP  = 2;
  localparam int unsigned STALL_LEN = 5;

  typedef struct packed {
    logic busy;
    logic write;
    logic data;
    logic dcare;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_in = '1;
  logic             valid_in = 1'b1;
  logic             ready_out;
  logic             stall_in = 1'b0;
  logic             data_out;
  logic             write_out;
  logic             busy_out;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;
  logic wr_prev = 1'b0;

  byte_serializer #(
    .WIDTH   (WIDTH),
    .BIT_HOLD(BIT_HOLD),
    .BIT_GAP (BIT_GAP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .stall_in (stall_in),
    .data_out (data_out),
    .write_out(write_out),
    .busy_out (busy_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_out && !wr_prev) pulse_cnt <= pulse_cnt + 1;
    wr_prev <= write_out;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_bit(input logic [WIDTH-1:0] w, input int i);
`ifdef BYTE_SERIALIZER_LSB_FIRST_EN
    return w[i];
`else
    return w[WIDTH-1-i];
`endif
  endfunction

  // Sends w; stall_bit >= 0 raises stall_in on that bit's first gap cycle for STALL_LEN cycles.
  task automatic play(input logic [WIDTH-1:0] w, input int stall_bit,
                      input bit keep_valid, input logic [WIDTH-1:0] next_w);
    exp_t trace[$];
    exp_t e;
    int   n;
    int   stall_start;
    int   wait_len;
    logic [3:0] got;
    logic [3:0] want;
    stall_start = 1 + stall_bit * (BIT_HOLD + BIT_GAP) + BIT_HOLD;
    // Gap finishes, then WAIT lasts until the edge after stall_in drops.
    wait_len = STALL_LEN + 1 - BIT_GAP;
    for (int i = 0; i < WIDTH; i++) begin
      for (int c = 0; c < BIT_HOLD; c++) trace.push_back('{1'b1, 1'b1, model_bit(w, i), 1'b1});
      for (int c = 0; c < BIT_GAP; c++)  trace.push_back('{1'b1, 1'b0, model_bit(w, i), 1'b1});
      if (i == stall_bit)
        for (int c = 0; c < wait_len; c++) trace.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
    end
    data_in  = w;
    valid_in = 1'b1;
    n = 0;
    while (!ready_out && n < 200) begin
      tick();
      n++;
    end
    if (!ready_out) begin
      check_eq("accept_timeout", 32'(ready_out), 32'd1);
      valid_in = 1'b0;
      return;
    end
    tick();
    valid_in = keep_valid;
    data_in  = keep_valid ? next_w : WIDTH'($urandom);
    for (int t = 1; t <= trace.size(); t++) begin
      e    = trace[t-1];
      got  = {ready_out, busy_out, write_out, e.dcare ? data_out : 1'b0};
      want = {1'b0, e.busy, e.write, e.dcare ? e.data : 1'b0};
      check_eq($sformatf("frame_%0h_t%0d", w, t), 32'(got), 32'(want));
      if (stall_bit >= 0) stall_in = (t >= stall_start) && (t < stall_start + STALL_LEN);
      tick();
    end
    stall_in = 1'b0;
    check_eq($sformatf("done_%0h", w), 32'({ready_out, busy_out, write_out}), 32'b100);
  endtask

  initial begin
    int base;
    logic [WIDTH-1:0] w;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("reset", 32'({ready_out, busy_out, write_out, data_out}), 32'd0);
    end
    rst      = 1'b0;
    valid_in = 1'b0;
    #1;
    check_eq("ready_after_rst", 32'({ready_out, busy_out}), 32'b10);

    base = pulse_cnt;
    play(8'hA5, -1, 1'b0, '0);
    check_eq("pulses_a5", 32'(pulse_cnt - base), 32'(WIDTH));

    play(WIDTH'($urandom), 3, 1'b0, '0);

    base = pulse_cnt;
    play(8'hFF, -1, 1'b1, 8'h00);
    play(8'h00, -1, 1'b0, '0);
    check_eq("b2b_pulses", 32'(pulse_cnt - base), 32'(2 * WIDTH));

    data_in  = 8'h3C;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    for (int i = 0; i < 3 * (BIT_HOLD + BIT_GAP); i++) tick();
    check_eq("midword_busy", 32'(busy_out), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("rst_midword", 32'({ready_out, busy_out, write_out, data_out}), 32'd0);
    rst = 1'b0;
    play(8'h81, -1, 1'b0, '0);

    for (int k = 0; k < 6; k++) begin
      w = WIDTH'($urandom);
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      play(w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, WIDTH - 2)) : -1,
           1'b0, '0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
